// File: rtl/viterbi_traceback_if.sv
// Step-beat input and decoded-state output channels of the Viterbi traceback block.
// The master drives steps in and consumes decoded states; the slave is the traceback block.
interface viterbi_traceback_if #(
   parameter int unsigned I = 3,
   parameter int unsigned W = 20,
   parameter int unsigned N = 64
);
   localparam int unsigned SW = (I > 1) ? $clog2(I) : 1;
   localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;

   logic                   in_valid;
   logic                   in_ready;
   logic [I-1:0][SW-1:0]   in_psi;
   logic [I-1:0][W-1:0]    in_delta;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [SW-1:0]          out_state;
   logic [NW-1:0]          out_idx;
   logic                   out_last;

   modport master (
      output in_valid, in_psi, in_delta, in_last, out_ready,
      input  in_ready, out_valid, out_state, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_psi, in_delta, in_last, out_ready,
      output in_ready, out_valid, out_state, out_idx, out_last
   );
endinterface

// File: rtl/viterbi_traceback.sv
// Viterbi back end: stores per-step backpointers, picks the best final state,
// walks the pointers backwards and streams the decoded path in forward order.
module viterbi_traceback #(
   parameter int unsigned I = 3,
   parameter int unsigned W = 20,
   parameter int unsigned N = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   viterbi_traceback_if.slave bus,
   output logic               busy,
   output logic               err_ovf
);
   localparam int unsigned SW = (I > 1) ? $clog2(I) : 1;
   localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
   localparam logic [NW-1:0] T_MAX = NW'(N - 1);

   typedef enum logic [1:0] {COLLECT, TRACE, EMIT} state_t;

   state_t               state, state_nxt;
   logic [NW-1:0]        t, ptr, e, len_m1;
   logic [SW-1:0]        cur, best, trace_nxt;
   logic signed [W-1:0]  best_val;
   logic                 accept, last_beat, emit_hs;

   logic [I-1:0][SW-1:0] psi_mem  [N];
   logic [SW-1:0]        path_mem [N];

   assign accept    = bus.in_valid && (state == COLLECT);
   assign last_beat = bus.in_last || (t == T_MAX);
   assign emit_hs   = (state == EMIT) && bus.out_ready;
   assign trace_nxt = psi_mem[ptr][cur];

   // Strict > keeps the lowest index on ties.
   always_comb begin
      best     = '0;
      best_val = $signed(bus.in_delta[0]);
      for (int unsigned j = 1; j < I; j++) begin
         if ($signed(bus.in_delta[j]) > best_val) begin
            best_val = $signed(bus.in_delta[j]);
            best     = SW'(j);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         COLLECT: if (accept && last_beat) state_nxt = (t == '0) ? EMIT : TRACE;
         TRACE:   if (ptr == NW'(1)) state_nxt = EMIT;
         EMIT:    if (emit_hs && (e == len_m1)) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t       <= '0;
         ptr     <= '0;
         e       <= '0;
         len_m1  <= '0;
         cur     <= '0;
         err_ovf <= 1'b0;
      end else begin
         unique case (state)
            COLLECT: begin
               if (accept) begin
                  if (last_beat) begin
                     cur    <= best;
                     ptr    <= t;
                     len_m1 <= t;
                     e      <= '0;
                     if (!bus.in_last) err_ovf <= 1'b1;
                  end else begin
                     t <= t + 1'b1;
                  end
               end
            end
            TRACE: begin
               cur <= trace_nxt;
               ptr <= ptr - 1'b1;
            end
            EMIT: begin
               if (emit_hs) begin
                  if (e == len_m1) begin
                     e <= '0;
                     t <= '0;
                  end else begin
                     e <= e + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Memories carry no reset; every location read is written earlier in the same sequence.
   always_ff @(posedge clk) begin
      if (accept) psi_mem[t] <= bus.in_psi;
      if (accept && last_beat) path_mem[t] <= best;
      if (state == TRACE) path_mem[ptr - 1'b1] <= trace_nxt;
   end

   assign bus.in_ready  = (state == COLLECT);
   assign bus.out_valid = (state == EMIT);
   assign bus.out_state = (state == EMIT) ? path_mem[e] : '0;
   assign bus.out_idx   = e;
   assign bus.out_last  = (state == EMIT) && (e == len_m1);
   assign busy          = (state != COLLECT);
endmodule
